// File: rtl/ecc_smul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ecc_smul_ctrl
// Description : Scalar-multiplication sequencer, R = k*P on
//               y^2 = x^3 + a*x + b (mod prime), left-to-right double-and-add.
//               Drives one shared point-add/double engine. Point-at-infinity,
//               inverse-point and y==0 doubling cases are resolved locally, so
//               the engine only ever sees finite, non-degenerate operands.
//
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               in_valid, in_Px, in_Py,
//               in_k, in_prime, in_a     - job request (captured only in IDLE)
//               out_valid, out_Rx,
//               out_Ry, out_inf          - one-cycle result (zero otherwise)
//               eng_in_valid, eng_P*/Q*,
//               eng_prime, eng_a         - registered engine request
//               eng_out_valid, eng_R*    - engine response
//
// Build option: define ECC_SMUL_SKIP_LZ_EN to skip the leading-zero bits of k
//               (LOAD jumps straight to the MSB set bit). Results are identical
//               with or without it; only latency changes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_smul_ctrl #(
    parameter int W   = 6,
    parameter int K_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   in_Px,
    input  logic [W-1:0]   in_Py,
    input  logic [K_W-1:0] in_k,
    input  logic [W-1:0]   in_prime,
    input  logic [W-1:0]   in_a,
    output logic           out_valid,
    output logic [W-1:0]   out_Rx,
    output logic [W-1:0]   out_Ry,
    output logic           out_inf,
    output logic           eng_in_valid,
    output logic [W-1:0]   eng_Px,
    output logic [W-1:0]   eng_Py,
    output logic [W-1:0]   eng_Qx,
    output logic [W-1:0]   eng_Qy,
    output logic [W-1:0]   eng_prime,
    output logic [W-1:0]   eng_a,
    input  logic           eng_out_valid,
    input  logic [W-1:0]   eng_Rx,
    input  logic [W-1:0]   eng_Ry
);

    localparam int c_IDX_W = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(K_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_DBL   = 3'd2;
    localparam logic [2:0] c_DBL_W = 3'd3;
    localparam logic [2:0] c_ADD_C = 3'd4;
    localparam logic [2:0] c_ADD_W = 3'd5;
    localparam logic [2:0] c_NEXT  = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    logic [2:0]         r_state;

    // Captured job
    logic [W-1:0]       r_px;
    logic [W-1:0]       r_py;
    logic [K_W-1:0]     r_k;
    logic [W-1:0]       r_prime;
    logic [W-1:0]       r_a;

    // Accumulator point and current scalar bit index
    logic [W-1:0]       r_acc_x;
    logic [W-1:0]       r_acc_y;
    logic               r_acc_inf;
    logic [c_IDX_W-1:0] r_idx;

    // Engine request registers (held until the next request)
    logic               r_eng_in_valid;
    logic [W-1:0]       r_eng_px;
    logic [W-1:0]       r_eng_py;
    logic [W-1:0]       r_eng_qx;
    logic [W-1:0]       r_eng_qy;
    logic [W-1:0]       r_eng_prime;
    logic [W-1:0]       r_eng_a;

    logic               w_done;
    logic               w_k_bit;
    logic               w_x_match;
    logic               w_y_match;

    assign w_done    = (r_state == c_DONE);
    assign w_k_bit   = r_k[r_idx];
    assign w_x_match = (r_acc_x == r_px);
    assign w_y_match = (r_acc_y == r_py);

`ifdef ECC_SMUL_SKIP_LZ_EN
    // Position of the most significant set bit of the captured scalar.
    logic [c_IDX_W-1:0] w_msb;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < K_W; i++) begin
            if (r_k[i]) begin
                w_msb = c_IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_px           <= '0;
            r_py           <= '0;
            r_k            <= '0;
            r_prime        <= '0;
            r_a            <= '0;
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            r_acc_inf      <= 1'b0;
            r_idx          <= '0;
            r_eng_in_valid <= 1'b0;
            r_eng_px       <= '0;
            r_eng_py       <= '0;
            r_eng_qx       <= '0;
            r_eng_qy       <= '0;
            r_eng_prime    <= '0;
            r_eng_a        <= '0;
        end else begin
            // Engine request is a single-cycle pulse; operands stay put.
            r_eng_in_valid <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_px    <= in_Px;
                        r_py    <= in_Py;
                        r_k     <= in_k;
                        r_prime <= in_prime;
                        r_a     <= in_a;
                        r_state <= c_LOAD;
                    end
                end

                c_LOAD: begin
`ifdef ECC_SMUL_SKIP_LZ_EN
                    if (r_k == '0) begin
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_acc_inf <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        // The MSB iteration always ends with acc = P, so
                        // start there and skip its doubling entirely.
                        r_acc_x   <= r_px;
                        r_acc_y   <= r_py;
                        r_acc_inf <= 1'b0;
                        r_idx     <= w_msb;
                        r_state   <= c_NEXT;
                    end
`else
                    r_acc_x   <= '0;
                    r_acc_y   <= '0;
                    r_acc_inf <= 1'b1;
                    r_idx     <= c_IDX_TOP;
                    r_state   <= c_DBL;
`endif
                end

                c_DBL: begin
                    if (r_acc_inf) begin
                        r_state <= c_ADD_C;
                    end else if (r_acc_y == '0) begin
                        // Tangent is vertical: 2*acc is the point at infinity.
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_acc_inf <= 1'b1;
                        r_state   <= c_ADD_C;
                    end else begin
                        r_eng_in_valid <= 1'b1;
                        r_eng_px       <= r_acc_x;
                        r_eng_py       <= r_acc_y;
                        r_eng_qx       <= r_acc_x;
                        r_eng_qy       <= r_acc_y;
                        r_eng_prime    <= r_prime;
                        r_eng_a        <= r_a;
                        r_state        <= c_DBL_W;
                    end
                end

                c_DBL_W, c_ADD_W: begin
                    if (eng_out_valid) begin
                        r_acc_x   <= eng_Rx;
                        r_acc_y   <= eng_Ry;
                        r_acc_inf <= 1'b0;
                        r_state   <= (r_state == c_DBL_W) ? c_ADD_C : c_NEXT;
                    end
                end

                c_ADD_C: begin
                    if (!w_k_bit) begin
                        r_state <= c_NEXT;
                    end else if (r_acc_inf) begin
                        r_acc_x   <= r_px;
                        r_acc_y   <= r_py;
                        r_acc_inf <= 1'b0;
                        r_state   <= c_NEXT;
                    end else if (w_x_match && (!w_y_match || (r_py == '0))) begin
                        // acc == -P, or acc == P with a vertical tangent:
                        // the sum is the point at infinity.
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_acc_inf <= 1'b1;
                        r_state   <= c_NEXT;
                    end else begin
                        // acc == P (y != 0) lands here too; the engine
                        // doubles when handed two equal points.
                        r_eng_in_valid <= 1'b1;
                        r_eng_px       <= r_acc_x;
                        r_eng_py       <= r_acc_y;
                        r_eng_qx       <= r_px;
                        r_eng_qy       <= r_py;
                        r_eng_prime    <= r_prime;
                        r_eng_a        <= r_a;
                        r_state        <= c_ADD_W;
                    end
                end

                c_NEXT: begin
                    if (r_idx == '0) begin
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx - c_IDX_ONE;
                        r_state <= c_DBL;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Result is presented straight from the accumulator in the DONE cycle
    // and forced to zero at all other times.
    assign out_valid = w_done;
    assign out_inf   = w_done & r_acc_inf;
    assign out_Rx    = (w_done && !r_acc_inf) ? r_acc_x : '0;
    assign out_Ry    = (w_done && !r_acc_inf) ? r_acc_y : '0;

    assign eng_in_valid = r_eng_in_valid;
    assign eng_Px       = r_eng_px;
    assign eng_Py       = r_eng_py;
    assign eng_Qx       = r_eng_qx;
    assign eng_Qy       = r_eng_qy;
    assign eng_prime    = r_eng_prime;
    assign eng_a        = r_eng_a;

endmodule
`default_nettype wire

// File: tb/tb_ecc_smul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ecc_smul_ctrl
// Description : Self-checking bench for ecc_smul_ctrl. A behavioural engine
//               with random latency answers requests; results are compared
//               against an affine-arithmetic reference computing k*P by
//               repeated point addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_smul_ctrl;

    localparam int W   = 6;
    localparam int K_W = 8;

    typedef struct {
        int x;
        int y;
        bit inf;
    } pt_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_Px;
    logic [W-1:0]   in_Py;
    logic [K_W-1:0] in_k;
    logic [W-1:0]   in_prime;
    logic [W-1:0]   in_a;
    logic           out_valid;
    logic [W-1:0]   out_Rx;
    logic [W-1:0]   out_Ry;
    logic           out_inf;
    logic           eng_in_valid;
    logic [W-1:0]   eng_Px;
    logic [W-1:0]   eng_Py;
    logic [W-1:0]   eng_Qx;
    logic [W-1:0]   eng_Qy;
    logic [W-1:0]   eng_prime;
    logic [W-1:0]   eng_a;
    logic           eng_out_valid;
    logic [W-1:0]   eng_Rx;
    logic [W-1:0]   eng_Ry;

    // Engine model state (written only by the engine process)
    logic           m_ov;
    logic [W-1:0]   m_rx;
    logic [W-1:0]   m_ry;
    int             eng_calls;
    int             eng_bad_ops;
    int             eng_bad_hold;

    // Written only by the main process
    logic           inj_ov;
    int             lat_override;
    int             cur_prime;
    int             cur_a;
    int             checks;
    int             errors;

    assign eng_out_valid = m_ov | inj_ov;
    assign eng_Rx        = m_rx;
    assign eng_Ry        = m_ry;

    ecc_smul_ctrl #(.W(W), .K_W(K_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_Px        (in_Px),
        .in_Py        (in_Py),
        .in_k         (in_k),
        .in_prime     (in_prime),
        .in_a         (in_a),
        .out_valid    (out_valid),
        .out_Rx       (out_Rx),
        .out_Ry       (out_Ry),
        .out_inf      (out_inf),
        .eng_in_valid (eng_in_valid),
        .eng_Px       (eng_Px),
        .eng_Py       (eng_Py),
        .eng_Qx       (eng_Qx),
        .eng_Qy       (eng_Qy),
        .eng_prime    (eng_prime),
        .eng_a        (eng_a),
        .eng_out_valid(eng_out_valid),
        .eng_Rx       (eng_Rx),
        .eng_Ry       (eng_Ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic int md(input int v, input int p);
        int r;
        r = v % p;
        if (r < 0) r = r + p;
        return r;
    endfunction

    function automatic int inv(input int v, input int p);
        for (int i = 1; i < p; i++) begin
            if (md(v * i, p) == 1) return i;
        end
        return 0;
    endfunction

    function automatic pt_t ec_add(input pt_t u, input pt_t v, input int p, input int a);
        pt_t r;
        int  lam;
        r.x = 0; r.y = 0; r.inf = 1'b1;
        if (u.inf) return v;
        if (v.inf) return u;
        if (u.x == v.x) begin
            if (md(u.y + v.y, p) == 0) return r;
            lam = md((3 * u.x * u.x + a) * inv(md(2 * u.y, p), p), p);
        end else begin
            lam = md(md(v.y - u.y, p) * inv(md(v.x - u.x, p), p), p);
        end
        r.inf = 1'b0;
        r.x   = md(lam * lam - u.x - v.x, p);
        r.y   = md(lam * (u.x - r.x) - u.y, p);
        return r;
    endfunction

    function automatic pt_t smul(input int k, input pt_t pt, input int p, input int a);
        pt_t r;
        r.x = 0; r.y = 0; r.inf = 1'b1;
        for (int i = 0; i < k; i++) r = ec_add(r, pt, p, a);
        return r;
    endfunction

    // ---------------- behavioural engine ----------------
    initial begin : engine
        logic [W-1:0] s_px, s_py, s_qx, s_qy, s_pr, s_a;
        pt_t u, v, res;
        int  lat;
        bit  ab;
        m_ov = 1'b0; m_rx = '0; m_ry = '0;
        eng_calls = 0; eng_bad_ops = 0; eng_bad_hold = 0;
        forever begin
            @(negedge clk);
            if (eng_in_valid === 1'b1 && rst === 1'b0) begin
                eng_calls++;
                s_px = eng_Px; s_py = eng_Py; s_qx = eng_Qx; s_qy = eng_Qy;
                s_pr = eng_prime; s_a = eng_a;
                if ((s_px == s_qx && s_py != s_qy) ||
                    (s_px == s_qx && s_py == s_qy && s_py == '0) ||
                    int'(s_pr) != cur_prime || int'(s_a) != cur_a)
                    eng_bad_ops++;
                u.x = int'(s_px); u.y = int'(s_py); u.inf = 1'b0;
                v.x = int'(s_qx); v.y = int'(s_qy); v.inf = 1'b0;
                res = ec_add(u, v, int'(s_pr), int'(s_a));
                lat = (lat_override > 0) ? lat_override : int'($urandom_range(1, 20));
                ab  = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                    else if (!ab && (eng_in_valid || eng_Px != s_px || eng_Py != s_py ||
                             eng_Qx != s_qx || eng_Qy != s_qy ||
                             eng_prime != s_pr || eng_a != s_a))
                        eng_bad_hold++;
                end
                if (!ab) begin
                    m_rx = res.x[W-1:0];
                    m_ry = res.y[W-1:0];
                    m_ov = 1'b1;
                    @(negedge clk);
                    m_ov = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at #1 after a rising edge; the request is sampled on the next edge.
    task automatic start_job(input int px, input int py, input int k, input int p, input int a);
        in_Px = W'(px); in_Py = W'(py); in_k = K_W'(k); in_prime = W'(p); in_a = W'(a);
        cur_prime = p; cur_a = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the LOAD cycle; returns in the cycle where out_valid is high.
    task automatic wait_done(output int rx, output int ry, output bit rinf,
                             output int cyc, output bit ok);
        ok = 1'b0; cyc = 1; rx = 0; ry = 0; rinf = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (out_valid) begin
                ok = 1'b1; rx = int'(out_Rx); ry = int'(out_Ry); rinf = out_inf;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!ok) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    task automatic run_job(input int px, input int py, input int k, input int p, input int a,
                           output int rx, output int ry, output bit rinf,
                           output int calls, output int cyc, output bit ok,
                           output bit post_v, output bit post_nz);
        int c0;
        c0 = eng_calls;
        start_job(px, py, k, p, a);
        wait_done(rx, ry, rinf, cyc, ok);
        calls = eng_calls - c0;
        @(posedge clk); #1;
        post_v  = out_valid;
        post_nz = (out_Rx != '0) || (out_Ry != '0) || out_inf;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_Rx !== '0 || out_Ry !== '0) begin errors++; $display("FAIL reset_out_R got (%0d,%0d) exp (0,0)", out_Rx, out_Ry); end
        checks++; if (out_inf !== 1'b0) begin errors++; $display("FAIL reset_out_inf got %b exp 0", out_inf); end
        checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL reset_eng_in_valid got %b exp 0", eng_in_valid); end
        checks++; if ({eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a} !== '0) begin
            errors++; $display("FAIL reset_eng_ops got %h exp 0", {eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_known_curve;
        int ks[6]    = '{1, 2, 5, 18, 19, 0};
        int ex[6]    = '{5, 6, 9, 5, 0, 0};
        int ey[6]    = '{1, 3, 16, 16, 0, 0};
        bit einf[6]  = '{0, 0, 0, 0, 1, 1};
        int ecall[6] = '{0, 1, 3, 5, 5, 0};
        int rx, ry, calls, cyc;
        bit rinf, ok, pv, pnz;
        for (int i = 0; i < 6; i++) begin
            run_job(5, 1, ks[i], 17, 2, rx, ry, rinf, calls, cyc, ok, pv, pnz);
            checks++; if (!ok) begin errors++; $display("FAIL known_k%0d_timeout no out_valid", ks[i]); end
            checks++; if (rx != ex[i] || ry != ey[i] || rinf != einf[i]) begin
                errors++; $display("FAIL known_k%0d_result got (%0d,%0d,inf=%0d) exp (%0d,%0d,inf=%0d)",
                                   ks[i], rx, ry, rinf, ex[i], ey[i], einf[i]);
            end
            checks++; if (calls != ecall[i]) begin errors++; $display("FAIL known_k%0d_calls got %0d exp %0d", ks[i], calls, ecall[i]); end
            checks++; if (pv !== 1'b0 || pnz !== 1'b0) begin errors++; $display("FAIL known_k%0d_pulse got valid=%0d nz=%0d exp 0 0", ks[i], pv, pnz); end
            if (ks[i] == 1) begin
`ifdef ECC_SMUL_SKIP_LZ_EN
                checks++; if (cyc != 3) begin errors++; $display("FAIL known_k1_latency got %0d exp 3", cyc); end
`else
                checks++; if (cyc != 2 + 3 * K_W) begin errors++; $display("FAIL known_k1_latency got %0d exp %0d", cyc, 2 + 3 * K_W); end
`endif
            end
            if (ks[i] == 0) begin
`ifdef ECC_SMUL_SKIP_LZ_EN
                checks++; if (cyc != 2) begin errors++; $display("FAIL known_k0_latency got %0d exp 2", cyc); end
`else
                checks++; if (cyc != 2 + 3 * K_W) begin errors++; $display("FAIL known_k0_latency got %0d exp %0d", cyc, 2 + 3 * K_W); end
`endif
            end
        end
    endtask

    task automatic test_small_curve;
        int px[3]    = '{0, 0, 0};
        int py[3]    = '{6, 0, 0};
        int kk[3]    = '{2, 2, 3};
        int ecall[3] = '{1, 0, 0};
        pt_t p0, e;
        int rx, ry, calls, cyc;
        bit rinf, ok, pv, pnz;
        for (int i = 0; i < 3; i++) begin
            p0.x = px[i]; p0.y = py[i]; p0.inf = 1'b0;
            e = smul(kk[i], p0, 7, 1);
            run_job(px[i], py[i], kk[i], 7, 1, rx, ry, rinf, calls, cyc, ok, pv, pnz);
            checks++; if (!ok || rx != e.x || ry != e.y || rinf != e.inf) begin
                errors++; $display("FAIL small_%0d_result got (%0d,%0d,inf=%0d) exp (%0d,%0d,inf=%0d)",
                                   i, rx, ry, rinf, e.x, e.y, e.inf);
            end
            checks++; if (calls != ecall[i]) begin errors++; $display("FAIL small_%0d_calls got %0d exp %0d", i, calls, ecall[i]); end
        end
    endtask

    task automatic test_ignore_in_valid;
        int rx, ry, cyc, c0;
        bit rinf, ok, seen;
        lat_override = 6;
        c0 = eng_calls;
        start_job(5, 1, 5, 17, 2);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (eng_calls - c0 >= 1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL ignore_inv_no_engine_call got 0 calls exp 1"); end
        // Controller is waiting on a doubling; a new request must be dropped.
        in_Px = 6'd9; in_Py = 6'd16; in_k = 8'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(rx, ry, rinf, cyc, ok);
        checks++; if (!ok || rx != 9 || ry != 16 || rinf) begin
            errors++; $display("FAIL ignore_inv_result got (%0d,%0d,inf=%0d) exp (9,16,inf=0)", rx, ry, rinf);
        end
        checks++; if (eng_calls - c0 != 3) begin errors++; $display("FAIL ignore_inv_calls got %0d exp 3", eng_calls - c0); end
        lat_override = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_stray_engine;
        int rx, ry, calls, cyc;
        bit rinf, ok, pv, pnz, seen;
        inj_ov = 1'b1;
        @(posedge clk); #1;
        inj_ov = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | out_valid | eng_in_valid;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL stray_eng_activity got 1 exp 0"); end
        run_job(5, 1, 2, 17, 2, rx, ry, rinf, calls, cyc, ok, pv, pnz);
        checks++; if (!ok || rx != 6 || ry != 3 || rinf) begin
            errors++; $display("FAIL stray_eng_result got (%0d,%0d,inf=%0d) exp (6,3,inf=0)", rx, ry, rinf);
        end
    endtask

    task automatic test_reset_mid;
        int rx, ry, calls, cyc, c0;
        bit rinf, ok, pv, pnz, seen;
        lat_override = 20;
        c0 = eng_calls;
        start_job(5, 1, 3, 17, 2);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (eng_calls - c0 >= 2) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL reset_mid_no_add_call got %0d calls exp 2", eng_calls - c0); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, out_Rx, out_Ry, out_inf, eng_in_valid,
                       eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got nonzero exp all 0 (valid=%b Rx=%0d engPx=%0d)",
                               out_valid, out_Rx, eng_Px);
        end
        rst = 1'b0;
        lat_override = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL reset_mid_pulse got out_valid=1 exp 0"); end
        run_job(5, 1, 19, 17, 2, rx, ry, rinf, calls, cyc, ok, pv, pnz);
        checks++; if (!ok || rx != 0 || ry != 0 || !rinf) begin
            errors++; $display("FAIL reset_mid_fresh got (%0d,%0d,inf=%0d) exp (0,0,inf=1)", rx, ry, rinf);
        end
    endtask

    task automatic test_back_to_back;
        int rx, ry, cyc;
        bit rinf, ok;
        start_job(5, 1, 5, 17, 2);
        wait_done(rx, ry, rinf, cyc, ok);
        checks++; if (!ok || rx != 9 || ry != 16 || rinf) begin
            errors++; $display("FAIL b2b_first got (%0d,%0d,inf=%0d) exp (9,16,inf=0)", rx, ry, rinf);
        end
        // Request in the DONE cycle: must be dropped.
        start_job(5, 1, 2, 17, 2);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got %b exp 0", out_valid); end
        // Request in the very next (IDLE) cycle: must be taken.
        start_job(5, 1, 18, 17, 2);
        wait_done(rx, ry, rinf, cyc, ok);
        checks++; if (!ok || rx != 5 || ry != 16 || rinf) begin
            errors++; $display("FAIL b2b_second got (%0d,%0d,inf=%0d) exp (5,16,inf=0)", rx, ry, rinf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int primes[15] = '{7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
        int p, a, b, k, disc;
        pt_t p0, e;
        int rx, ry, calls, cyc;
        bit rinf, ok, pv, pnz;
        for (int n = 0; n < 24; n++) begin
            p = primes[$urandom_range(0, 14)];
            for (int t = 0; t < 100; t++) begin
                a    = int'($urandom_range(0, p - 1));
                p0.x = int'($urandom_range(0, p - 1));
                p0.y = int'($urandom_range(0, p - 1));
                b    = md(p0.y * p0.y - p0.x * p0.x * p0.x - a * p0.x, p);
                disc = md(4 * a * a * a + 27 * b * b, p);
                if (disc != 0) break;
            end
            p0.inf = 1'b0;
            k = int'($urandom_range(0, (1 << K_W) - 1));
            e = smul(k, p0, p, a);
            run_job(p0.x, p0.y, k, p, a, rx, ry, rinf, calls, cyc, ok, pv, pnz);
            checks++; if (!ok || rx != e.x || ry != e.y || rinf != e.inf) begin
                errors++; $display("FAIL rand_%0d_result p=%0d a=%0d P=(%0d,%0d) k=%0d got (%0d,%0d,inf=%0d) exp (%0d,%0d,inf=%0d)",
                                   n, p, a, p0.x, p0.y, k, rx, ry, rinf, e.x, e.y, e.inf);
            end
            checks++; if (pv !== 1'b0 || pnz !== 1'b0) begin
                errors++; $display("FAIL rand_%0d_idle_outputs got valid=%0d nz=%0d exp 0 0", n, pv, pnz);
            end
        end
    endtask

    task automatic test_engine_protocol;
        checks++; if (eng_bad_ops != 0) begin errors++; $display("FAIL eng_operands_legal got %0d bad requests exp 0", eng_bad_ops); end
        checks++; if (eng_bad_hold != 0) begin errors++; $display("FAIL eng_operands_held got %0d violations exp 0", eng_bad_hold); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0;
        in_Px = '0; in_Py = '0; in_k = '0; in_prime = '0; in_a = '0;
        inj_ov = 1'b0; lat_override = 0; cur_prime = 0; cur_a = 0;
        test_reset;
        test_known_curve;
        test_small_curve;
        test_ignore_in_valid;
        test_stray_engine;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_engine_protocol;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_smul_ctrl.md
Name: ecc_smul_ctrl

Overview:
Scalar-multiplication sequencer that computes R = k·P on y² = x³ + a·x + b (mod prime) using left-to-right double-and-add. It drives one shared ECC point-add/double engine, with the same in_valid / out_valid / Px..a / Rx,Ry handshake used by the lab point-add block. Point-at-infinity and inverse-point cases are resolved locally, so the engine only ever receives finite, non-degenerate operand pairs.

Parameters:
W, 6, coordinate/prime/a width
K_W, 8, scalar width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle request pulse
in_Px, in_Py  in  W  base point P, on curve, each < prime
in_k  in  K_W  scalar, unsigned
in_prime  in  W  odd prime, 3..2^W-1
in_a  in  W  curve coefficient a, < prime
out_valid  out  1  one-cycle result pulse
out_Rx, out_Ry  out  W  result; 0 when out_valid=0
out_inf  out  1  result is point at infinity (Rx=Ry=0); 0 when out_valid=0
eng_in_valid  out  1  engine request pulse
eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a  out  W  engine operands
eng_out_valid  in  1  engine done pulse
eng_Rx, eng_Ry  in  W  engine result

Behaviour:
- Reset (synchronous, active-high, sampled on clk): state=IDLE; all outputs 0, including eng_* operands. A reset mid-operation aborts the job at the next edge. No output pulse is produced.
- Input capture: in IDLE, in_valid=1 captures all inputs. in_valid is ignored in every other state; there is no queueing.
- Registers: acc (x,y,inf), bit index idx, captured P/k/prime/a.
- States and transitions:
  - IDLE
  - LOAD: acc=O, idx=K_W-1.
  - DBL: 1 cycle. If acc.inf, acc stays O. If acc.y==0, acc=O. Otherwise pulse eng_in_valid with P=Q=acc, then go to DBL_W.
  - DBL_W: wait for eng_out_valid, latch acc=eng_R, go to ADD_C.
  - ADD_C: 1 cycle. If k[idx]==0, go to NEXT. If acc.inf, acc=P. If acc.x==P.x and acc.y!=P.y, acc=O. If acc==P and P.y==0, acc=O. Otherwise pulse eng_in_valid with P=acc, Q=P (equal points mean the engine doubles), then go to ADD_W.
  - ADD_W: latch as in DBL_W.
  - NEXT: if idx==0, go to DONE; else idx-1, go to DBL.
  - DONE: out_valid=1 for one cycle with out_Rx/out_Ry/out_inf from acc, then go to IDLE.
- eng_in_valid is exactly 1 cycle. eng_* operands are registered and held stable from the request cycle until eng_out_valid. eng_out_valid outside DBL_W/ADD_W is ignored.
- Engine latency is arbitrary and ≥1. There is no timeout; the controller waits indefinitely.
- k=0 gives out_inf=1 with zero engine calls.
- Throughput: a new in_valid is accepted the cycle after out_valid. A back-to-back request with in_valid in the DONE cycle is ignored.
- Modular comparisons are on raw W-bit values; inputs are already reduced.

Optional Feature:
Macro ECC_SMUL_SKIP_LZ_EN.
- Defined: LOAD scans in_k for its MSB set bit m. It sets acc=P, idx=m, and goes to NEXT, so leading-zero iterations cost 0 cycles and the first doubling is skipped. If k=0, go straight to DONE with out_inf=1.
- Undefined: all K_W bits are iterated from LOAD as described in Behaviour.
- Results are identical either way; only latency differs.

Test Plan:
- Curve a=2, prime=17, P=(5,1), k=1 → out (5,1), out_inf=0, 0 engine calls. Without the macro: 2+3·K_W cycles from LOAD to out_valid, excluding engine waits (none here).
- Same curve, k=2 → (6,3), 1 engine call. k=5 → (9,16), 3 calls. k=18 → (5,16). Bench uses a behavioural engine with random latency 1..20.
- Same curve, k=19 (order) → out_inf=1, Rx=Ry=0. The final add is resolved locally via inverse-x match; 5 calls with ECC_SMUL_SKIP_LZ_EN defined.
- k=0 → out_inf=1, 0 engine calls. P=(0,6) on a=1, prime=7 (y≠0) with k=2 → engine invoked once. A curve point with y=0 and k=2 → out_inf=1, no call.
- in_valid pulsed during DBL_W → ignored, result unchanged. Engine out_valid injected in IDLE → no effect. rst=1 during ADD_W → next cycle all outputs 0, no out_valid. A fresh job then completes correctly.
- Reset check: rst=1 for 2 cycles → out_valid, out_Rx, out_Ry, out_inf, eng_in_valid all 0.
